// File: rtl/aont_pkg.sv
// Shared sizing, FSM state encoding and packet layout for the AONT chaff inserter.
package aont_pkg;
   localparam int DEF_NOOFBLOCKS = 8;
   localparam int DEF_LSLEN      = 16;
   localparam int DEF_LSLENLOG   = 4;
   localparam int BLKLEN         = DEF_LSLEN * DEF_LSLENLOG;
   localparam int MSGLEN         = BLKLEN * DEF_NOOFBLOCKS;

   typedef enum logic [1:0] {IDLE, TAG, EMIT_A, EMIT_B} state_t;

   typedef struct packed {
      logic [$clog2(DEF_NOOFBLOCKS)-1:0] serial;
      logic [BLKLEN-1:0]                 data;
      logic [DEF_LSLENLOG-1:0]           tag;
   } pkt_t;
endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rstn,
   output logic [15:0] state
);
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= SEED;
      else       state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
   end
endmodule

// File: rtl/chaff_inserter.sv
// Splits a message into blocks, tags each block, and emits a wheat/chaff packet pair per block.
// Emit order within a pair is chosen by an LFSR bit; outputs hold while out_ready is low.
module chaff_inserter
   import aont_pkg::*;
#(
   parameter int          NOOFBLOCKS = DEF_NOOFBLOCKS,
   parameter int          LSLEN      = DEF_LSLEN,
   parameter int          LSLENLOG   = DEF_LSLENLOG,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [LSLEN*LSLENLOG*NOOFBLOCKS-1:0] msg_in,
   input  logic [LSLENLOG-1:0]                  tag_key,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [LSLEN*LSLENLOG-1:0]            out_data,
   output logic [$clog2(NOOFBLOCKS)-1:0]        out_serial,
   output logic [LSLENLOG-1:0]                  out_tag,
   output logic                                 msg_done
);
   localparam int BW = LSLEN * LSLENLOG;
   localparam int SW = $clog2(NOOFBLOCKS);
   localparam int NW = $clog2(LSLEN);
   localparam logic [SW-1:0] LAST_BLK = SW'(NOOFBLOCKS - 1);
   localparam logic [NW-1:0] LAST_NIB = NW'(LSLEN - 1);

   state_t                       state;
   logic [BW*NOOFBLOCKS-1:0]     msg_q;
   logic [LSLENLOG-1:0]          key_q;
   logic [LSLENLOG-1:0]          tag_acc;
   logic [SW-1:0]                blk_idx;
   logic [NW-1:0]                nib_cnt;
   logic [15:0]                  lfsr;
   pkt_t                         out_pkt;
   pkt_t                         alt_pkt;

   logic [BW-1:0]                blk;
   logic [LSLENLOG-1:0]          nib;
   logic [LSLENLOG-1:0]          tag_next;
   pkt_t                         wheat;
   pkt_t                         chaff;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rstn  (rstn),
      .state (lfsr)
   );

   always_comb begin
      blk      = msg_q[blk_idx*BW +: BW];
      nib      = blk[nib_cnt*LSLENLOG +: LSLENLOG];
      tag_next = (tag_acc + nib) ^ key_q;
      wheat    = '{serial: blk_idx, data: blk, tag: tag_next};
      chaff    = '{serial: blk_idx, data: blk ^ {(BW/16){lfsr}}, tag: tag_next ^ '1};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         msg_q     <= '0;
         key_q     <= '0;
         tag_acc   <= '0;
         blk_idx   <= '0;
         nib_cnt   <= '0;
         out_valid <= 1'b0;
         out_pkt   <= '0;
         alt_pkt   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               msg_q   <= msg_in;
               key_q   <= tag_key;
               tag_acc <= tag_key;
               blk_idx <= '0;
               nib_cnt <= '0;
               state   <= TAG;
            end
            TAG: begin
               tag_acc <= tag_next;
               nib_cnt <= nib_cnt + 1'b1;
               // Last nibble: tag_next is the final tag and lfsr is the latched r.
               if (nib_cnt == LAST_NIB) begin
                  out_valid <= 1'b1;
                  out_pkt   <= lfsr[0] ? chaff : wheat;
                  alt_pkt   <= lfsr[0] ? wheat : chaff;
                  state     <= EMIT_A;
               end
            end
            EMIT_A: if (out_ready) begin
               out_pkt <= alt_pkt;
               state   <= EMIT_B;
            end
            EMIT_B: if (out_ready) begin
               out_valid <= 1'b0;
               out_pkt   <= '0;
               tag_acc   <= key_q;
               nib_cnt   <= '0;
               if (blk_idx == LAST_BLK) begin
                  state <= IDLE;
               end else begin
                  blk_idx <= blk_idx + 1'b1;
                  state   <= TAG;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready   = (state == IDLE);
   assign msg_done   = (state == EMIT_B) && out_ready && (blk_idx == LAST_BLK);
   assign out_data   = out_pkt.data;
   assign out_serial = out_pkt.serial;
   assign out_tag    = out_pkt.tag;
endmodule
